// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank burst reader.
// Optional feature macro used by this slice: REGBANK_CLEAR_ON_READ_EN.
package regbank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;

    // Address width for a power-of-two depth (log2 of depth).
    function automatic int unsigned addr_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regbank_burst_reader_storage.sv
// DFF word array with one write port, one clear port and a combinational read port.
// The clear port is only driven by the top when REGBANK_CLEAR_ON_READ_EN is defined.
module regbank_storage
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] bank_q [DEPTH];

    // Storage update: clear first, write second so a same-address write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '{default: '0};
        end else begin
            if (clr_en_i) begin
                bank_q[clr_addr_i] <= '0;
            end
            if (wr_en_i) begin
                bank_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = bank_q[rd_addr_i];

endmodule

// File: rtl/regbank_burst_reader.sv
// Burst reader over a small DFF register bank: streams a wrapping address
// range out over valid/ready. Presented words are registered snapshots.
// Macro REGBANK_CLEAR_ON_READ_EN: clear each word as it transfers.
module regbank_burst_reader
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
    // Words still to present after the one currently on the outputs.
    logic [ADDR_W:0]     rem_q, rem_d;

    logic [ADDR_W:0]     len_eff;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                xfer;
    logic                clr_en;

    assign len_eff = (rd_len > LEN_MAX) ? LEN_MAX : rd_len;
    assign xfer    = (state_q == STREAM) && out_valid_q && out_ready;
    // In IDLE the bank is read at the burst base; while streaming, at the next address.
    assign rd_addr = (state_q == IDLE) ? rd_base : (out_addr_q + ADDR_ONE);

`ifdef REGBANK_CLEAR_ON_READ_EN
    assign clr_en = xfer;
`else
    assign clr_en = 1'b0;
`endif

    regbank_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clr_en_i   (clr_en),
        .clr_addr_i (out_addr_q),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data)
    );

    // Next-state and output-register load logic for the burst FSM.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (rd_start && (rd_len != '0)) begin
                    state_d     = STREAM;
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_addr_d  = rd_base;
                    out_last_d  = (len_eff == CNT_ONE);
                    rem_d       = len_eff - CNT_ONE;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_data_d = rd_data;
                        out_addr_d = out_addr_q + ADDR_ONE;
                        out_last_d = (rem_q == CNT_ONE);
                        rem_d      = rem_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            rem_q       <= rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == STREAM);

endmodule
